wb_elf_loader: RTL and testbench

WB_ELF_LOADER -- requirements
Module: wb_elf_loader

---
 rtl/wb_elf_loader.sv | 126 ++++++++++++
 tb/tb_wb_elf_loader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_elf_loader.sv
// Streams a word image into memory over a Wishbone master, holding the CPU in reset
// until the whole image has been acknowledged. Retries on rty, aborts on err.
module wb_elf_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h00000000,
  parameter int          MAX_WORDS   = 2000,
  parameter int          RETRY_LIMIT = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start_i,
  input  logic [31:0] length_i,
  input  logic [31:0] s_data_i,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic [2:0]  wbm_cti_o,
  output logic [1:0]  wbm_bte_o,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic        wbm_rty_i,
  output logic        cpu_rst_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [31:0] words_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_WRITE   = 3'd2;
  localparam logic [2:0] S_BACKOFF = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  localparam logic [2:0] S_ERROR   = 3'd5;

  localparam logic [31:0] MAX_LEN   = 32'(MAX_WORDS);
  localparam logic [31:0] RETRY_MAX = 32'(RETRY_LIMIT);

  logic [2:0]  r_state;
  logic [31:0] r_len;
  logic [31:0] r_count;
  logic [31:0] r_retry;
  logic [31:0] r_data;

  logic        w_write;
  logic [31:0] w_count_inc;

  assign w_write     = (r_state == S_WRITE);
  assign w_count_inc = r_count + 32'd1;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
      r_len   <= 32'd0;
      r_count <= 32'd0;
      r_retry <= 32'd0;
      r_data  <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            if (length_i == 32'd0) begin
              r_state <= S_DONE;
            end else if (length_i > MAX_LEN) begin
              r_state <= S_ERROR;
            end else begin
              r_len   <= length_i;
              r_count <= 32'd0;
              r_retry <= 32'd0;
              r_state <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          if (s_valid_i) begin
            r_data  <= s_data_i;
            r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          // err outranks rty, which outranks ack, when several arrive together
          if (wbm_err_i) begin
            r_state <= S_ERROR;
          end else if (wbm_rty_i) begin
            if (r_retry == RETRY_MAX) begin
              r_state <= S_ERROR;
            end else begin
              r_retry <= r_retry + 32'd1;
              r_state <= S_BACKOFF;
            end
          end else if (wbm_ack_i) begin
            r_count <= w_count_inc;
            r_retry <= 32'd0;
            r_state <= (w_count_inc == r_len) ? S_DONE : S_FETCH;
          end
        end
        S_BACKOFF: r_state <= S_WRITE;
        S_DONE:    r_state <= S_DONE;
        S_ERROR:   r_state <= S_ERROR;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  // Bus outputs are decoded from state so they read zero everywhere outside WRITE
  assign wbm_cyc_o = w_write;
  assign wbm_stb_o = w_write;
  assign wbm_we_o  = w_write;
  assign wbm_sel_o = w_write ? 4'hF : 4'h0;
  assign wbm_cti_o = 3'b000;
  assign wbm_bte_o = 2'b00;
  assign wbm_adr_o = w_write ? (BASE_ADDR + {r_count[29:0], 2'b00}) : 32'd0;
  assign wbm_dat_o = w_write ? r_data : 32'd0;

  assign s_ready_o = (r_state == S_FETCH);
  assign busy_o    = (r_state == S_FETCH) || w_write || (r_state == S_BACKOFF);
  assign done_o    = (r_state == S_DONE);
  assign error_o   = (r_state == S_ERROR);
  assign cpu_rst_o = (r_state != S_DONE);
  assign words_o   = r_count;

endmodule

// File: tb/tb_wb_elf_loader.sv
// Directed bench for wb_elf_loader: scripted Wishbone slave and word source,
// with a posedge monitor logging every bus attempt.
module tb_wb_elf_loader;

  localparam int MAXW = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] length = 32'd0;
  logic [31:0] s_data = 32'd0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] adr, dat;
  logic [3:0]  sel;
  logic        we, cyc, stb;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack = 1'b0, err = 1'b0, rty = 1'b0;
  logic        cpu_rst, busy, done, error;
  logic [31:0] words;

  wb_elf_loader #(.BASE_ADDR(32'h0), .MAX_WORDS(MAXW), .RETRY_LIMIT(4)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .length_i(length),
    .s_data_i(s_data), .s_valid_i(s_valid), .s_ready_o(s_ready),
    .wbm_adr_o(adr), .wbm_dat_o(dat), .wbm_sel_o(sel), .wbm_we_o(we),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_cti_o(cti), .wbm_bte_o(bte),
    .wbm_ack_i(ack), .wbm_err_i(err), .wbm_rty_i(rty),
    .cpu_rst_o(cpu_rst), .busy_o(busy), .done_o(done), .error_o(error),
    .words_o(words)
  );

  always #5 clk = ~clk;

  logic [31:0] src [0:7] = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004,
                             32'hEEEE_0005, 32'h1234_5678, 32'h0BAD_F00D, 32'hCAFE_BABE};

  // Slave/source scripting knobs
  int fetched = 0;
  int rty_left = 0;
  bit always_rty = 1'b0;
  int err_word = -1;
  int stall_word = -1;

  // Attempt log
  int          n_att = 0;
  int          cyc_no = 0;
  logic [31:0] log_adr [0:31];
  logic [31:0] log_dat [0:31];
  int          log_cyc [0:31];
  logic [3:0]  log_sel [0:31];

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  always @(posedge clk) begin
    cyc_no++;
    if (!rst && cyc && stb) begin
      if (n_att < 32) begin
        log_adr[n_att] = adr;
        log_dat[n_att] = dat;
        log_cyc[n_att] = cyc_no;
        log_sel[n_att] = sel;
      end
      n_att++;
      if (rty && rty_left > 0) rty_left--;
    end
    if (!rst && s_valid && s_ready) fetched++;
  end

  always @(negedge clk) begin
    ack = 1'b0; rty = 1'b0; err = 1'b0;
    s_valid = (fetched < 8);
    s_data  = (fetched < 8) ? src[fetched] : 32'd0;
    if (cyc && stb && (int'(words) != stall_word)) begin
      if (always_rty || rty_left > 0) rty = 1'b1;
      else if (int'(words) == err_word) begin err = 1'b1; ack = 1'b1; end
      else ack = 1'b1;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    fetched = 0; rty_left = 0; always_rty = 1'b0; err_word = -1; stall_word = -1;
    n_att = 0;
  endtask

  task automatic start_load(input logic [31:0] len);
    start = 1'b1; length = len;
    @(negedge clk);
    start = 1'b0; length = 32'hFFFF_FFFF;
  endtask

  task automatic wait_end(input string tag, input int budget);
    int k = 0;
    while (!(done || error) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_terminates"}, {31'd0, done | error}, 32'd1);
  endtask

  initial begin
    // Reset values while reset is held
    @(negedge clk); @(negedge clk);
    check("rst_cyc", {31'd0, cyc}, 32'd0);
    check("rst_stb", {31'd0, stb}, 32'd0);
    check("rst_we", {31'd0, we}, 32'd0);
    check("rst_adr", adr, 32'd0);
    check("rst_dat", dat, 32'd0);
    check("rst_sel", {28'd0, sel}, 32'd0);
    check("rst_cti_bte", {27'd0, cti, bte}, 32'd0);
    check("rst_sready", {31'd0, s_ready}, 32'd0);
    check("rst_flags", {29'd0, busy, done, error}, 32'd0);
    check("rst_words", words, 32'd0);
    check("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);

    // Three words, zero-wait slave
    do_reset();
    start_load(32'd3);
    check("t1_busy", {31'd0, busy}, 32'd1);
    wait_end("t1", 50);
    $display("t1 len=3 attempts=%0d words=%0d done=%0d", n_att, words, done);
    check("t1_attempts", n_att, 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t1_adr%0d", i), log_adr[i], 32'(4 * i));
      check($sformatf("t1_dat%0d", i), log_dat[i], src[i]);
    end
    check("t1_sel", {28'd0, log_sel[0]}, 32'hF);
    check("t1_rate", 32'(log_cyc[1] - log_cyc[0]), 32'd2);
    check("t1_words", words, 32'd3);
    check("t1_done", {31'd0, done}, 32'd1);
    check("t1_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    check("t1_busy_end", {31'd0, busy}, 32'd0);

    // Two rty on word 0, then ack
    do_reset();
    rty_left = 2;
    start_load(32'd2);
    wait_end("t2", 50);
    $display("t2 len=2 rty=2 attempts=%0d words=%0d done=%0d", n_att, words, done);
    check("t2_attempts", n_att, 4);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t2_adr%0d", i), log_adr[i], 32'd0);
      check($sformatf("t2_dat%0d", i), log_dat[i], src[0]);
    end
    check("t2_gap", 32'(log_cyc[1] - log_cyc[0]), 32'd2);
    check("t2_adr3", log_adr[3], 32'd4);
    check("t2_words", words, 32'd2);
    check("t2_done", {31'd0, done}, 32'd1);

    // Slave always rty: retry limit exhausted
    do_reset();
    always_rty = 1'b1;
    start_load(32'd3);
    wait_end("t3", 60);
    $display("t3 always-rty attempts=%0d error=%0d words=%0d", n_att, error, words);
    check("t3_attempts", n_att, 5);
    check("t3_adr4", log_adr[4], 32'd0);
    check("t3_error", {31'd0, error}, 32'd1);
    check("t3_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("t3_words", words, 32'd0);
    start_load(32'd2);
    repeat (3) @(negedge clk);
    check("t3_sticky", {30'd0, error, busy}, 32'd2);

    // err together with ack on word 1 of 4
    do_reset();
    err_word = 1;
    start_load(32'd4);
    wait_end("t4", 50);
    repeat (4) @(negedge clk);
    $display("t4 err@1 attempts=%0d error=%0d words=%0d", n_att, error, words);
    check("t4_attempts", n_att, 2);
    check("t4_error", {31'd0, error}, 32'd1);
    check("t4_words", words, 32'd1);
    check("t4_cyc", {31'd0, cyc}, 32'd0);

    // Zero length: done on the next cycle
    do_reset();
    start_load(32'd0);
    $display("t5 len=0 done=%0d attempts=%0d", done, n_att);
    check("t5_done", {31'd0, done}, 32'd1);
    check("t5_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    check("t5_attempts", n_att, 0);

    // Oversize length rejected
    do_reset();
    start_load(32'(MAXW + 1));
    repeat (2) @(negedge clk);
    $display("t6 len=%0d error=%0d attempts=%0d", MAXW + 1, error, n_att);
    check("t6_error", {31'd0, error}, 32'd1);
    check("t6_attempts", n_att, 0);

    // Exactly MAX_WORDS accepted
    do_reset();
    start_load(32'(MAXW));
    wait_end("t7", 100);
    $display("t7 len=%0d attempts=%0d words=%0d", MAXW, n_att, words);
    check("t7_words", words, 32'(MAXW));
    check("t7_last_adr", log_adr[MAXW-1], 32'h1C);
    check("t7_last_dat", log_dat[MAXW-1], src[MAXW-1]);

    // Reset in the middle of word 2's bus cycle, then a fresh one-word load
    do_reset();
    stall_word = 2;
    start_load(32'd4);
    begin
      int k = 0;
      while (!(cyc && words == 32'd2) && k < 50) begin
        @(negedge clk);
        k++;
      end
    end
    check("t8_reach_w2", {31'd0, cyc}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t8_cyc_drop", {30'd0, cyc, stb}, 32'd0);
    check("t8_words_rst", words, 32'd0);
    check("t8_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    rst = 1'b0;
    fetched = 0; stall_word = -1; n_att = 0;
    @(negedge clk);
    start_load(32'd1);
    wait_end("t8", 50);
    $display("t8 restart attempts=%0d adr=%h words=%0d done=%0d", n_att, log_adr[0], words, done);
    check("t8_attempts", n_att, 1);
    check("t8_adr", log_adr[0], 32'd0);
    check("t8_dat", log_dat[0], src[0]);
    check("t8_words", words, 32'd1);
    check("t8_done", {31'd0, done}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
